// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - instruction queue between fetch and decode
// Circular buffer of {pc, inst}; compacting multi-lane push, all-or-nothing in-order pop.
module inst_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int N_ISSUE     = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   stall,
  input  logic [FETCH_WIDTH-1:0]                 fetch_valid,
  input  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] fetch_pc,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] fetch_inst,
  output logic                                   fetch_ready,
  output logic [N_ISSUE-1:0]                     out_valid,
  output logic [N_ISSUE-1:0][ADDR_WIDTH-1:0]     out_pc,
  output logic [N_ISSUE-1:0][DATA_WIDTH-1:0]     out_inst,
  output logic [$clog2(DEPTH+1)-1:0]             count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_push, n_pop;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_en, pop_en;

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem_d [DEPTH];

  // Readiness looks only at registered occupancy so fetch never waits on decode timing.
  assign fetch_ready = (count_q <= READY_MAX);
  assign count       = count_q;
  assign push_en     = fetch_ready & (|fetch_valid) & ~flush;
  assign pop_en      = ~stall & ~flush;

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      out_valid[i] = (count_q > CNT_W'(i));
      out_pc[i]    = pc_mem_q[head_q + PTR_W'(i)];
      out_inst[i]  = inst_mem_q[head_q + PTR_W'(i)];
    end
  end

  always_comb begin
    n_pop = '0;
    if (pop_en) begin
      for (int i = 0; i < N_ISSUE; i++) begin
        n_pop = n_pop + CNT_W'(out_valid[i]);
      end
    end
  end

  // Valid lanes land in consecutive slots from tail; mask holes consume no slot.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    wr_ptr     = tail_q;
    n_push     = '0;
    if (push_en) begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        if (fetch_valid[l]) begin
          pc_mem_d[wr_ptr]   = fetch_pc[l];
          inst_mem_d[wr_ptr] = fetch_inst[l];
          wr_ptr             = wr_ptr + PTR_ONE;
          n_push             = n_push + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_pop);
      tail_d  = wr_ptr;
      count_d = count_q + n_push - n_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));
  a_pop_bound:   assert property (@(posedge clk) disable iff (!rst_n) n_pop <= count_q);

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed plus randomized bench for inst_queue
// Expected values come from a queue-of-entries reference model and literal constants.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int NI    = 1;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   stall;
  logic [FW-1:0]          fetch_valid;
  logic [FW-1:0][AW-1:0]  fetch_pc;
  logic [FW-1:0][DW-1:0]  fetch_inst;
  logic                   fetch_ready;
  logic [NI-1:0]          out_valid;
  logic [NI-1:0][AW-1:0]  out_pc;
  logic [NI-1:0][DW-1:0]  out_inst;
  logic [CW-1:0]          count;

  ent_t mq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  inst_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .N_ISSUE(NI), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_ready(fetch_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [FW-1:0] v, input logic [AW-1:0] pc0, input logic [AW-1:0] pc1);
    fetch_valid   = v;
    fetch_pc[0]   = pc0;
    fetch_pc[1]   = pc1;
    fetch_inst[0] = pc0 ^ 32'h5A5A_0000;
    fetch_inst[1] = pc1 ^ 32'h5A5A_0000;
  endtask

  // Compare outputs with the model, advance the model by the current inputs, clock once.
  task automatic tick();
    int sz;
    bit rdy;
    sz  = mq.size();
    rdy = (DEPTH - sz) >= FW;
    check("count", 64'(count), 64'(sz));
    check("fetch_ready", 64'(fetch_ready), 64'(rdy));
    for (int i = 0; i < NI; i++) begin
      check("out_valid", 64'(out_valid[i]), 64'(sz > i));
      if (sz > i) begin
        check("out_pc", 64'(out_pc[i]), 64'(mq[i].pc));
        check("out_inst", 64'(out_inst[i]), 64'(mq[i].inst));
      end
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (!stall) begin
        for (int i = 0; i < NI; i++) begin
          if (mq.size() > 0) void'(mq.pop_front());
        end
      end
      if (rdy) begin
        for (int l = 0; l < FW; l++) begin
          if (fetch_valid[l]) mq.push_back('{pc: fetch_pc[l], inst: fetch_inst[l]});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    drive('0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("reset_count", 64'(count), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_fetch_ready", 64'(fetch_ready), 64'd1);
    rst_n = 1'b1;

    // Basic two-lane push followed by in-order pops
    drive(2'b11, 32'h1000, 32'h1004);
    fetch_inst[0] = 32'hAAAA_0001;
    fetch_inst[1] = 32'hAAAA_0002;
    tick();
    drive('0, '0, '0);
    check("t1_count", 64'(count), 64'd2);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_pc0", 64'(out_pc[0]), 64'h1000);
    check("t1_inst0", 64'(out_inst[0]), 64'hAAAA_0001);
    tick();
    check("t1_pc1", 64'(out_pc[0]), 64'h1004);
    check("t1_count1", 64'(count), 64'd1);
    tick();
    check("t1_empty", 64'(count), 64'd0);

    // Fill to full under stall; extra group ignored; drain in order
    stall = 1'b1;
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, 32'h2000 + 32'(8*g), 32'h2004 + 32'(8*g));
      tick();
    end
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_full_ready", 64'(fetch_ready), 64'd0);
    drive(2'b11, 32'h2FF0, 32'h2FF4);
    tick();
    check("t2_ignored", 64'(count), 64'd8);
    stall = 1'b0;
    drive('0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      check("t2_drain_pc", 64'(out_pc[0]), 64'h2000 + 64'(4*k));
      tick();
    end
    check("t2_drained", 64'(count), 64'd0);

    // Holed mask: only lane 1 is enqueued
    drive(2'b10, 32'hDEAD_0000, 32'h3004);
    tick();
    drive('0, '0, '0);
    check("t3_count", 64'(count), 64'd1);
    check("t3_pc", 64'(out_pc[0]), 64'h3004);

    // Reset pulsed between edges while entries are present
    stall = 1'b1;
    drive(2'b11, 32'h4000, 32'h4004);
    tick();
    check("t4_pre_count", 64'(count), 64'd3);
    async_reset();

    // Pointer wrap: move head to 5, then run push/pop across slot 7 -> 0
    drive(2'b11, 32'h5000, 32'h5004); tick();
    drive(2'b11, 32'h5008, 32'h500C); tick();
    drive(2'b01, 32'h5010, 32'h0);    tick();
    check("t5_pre", 64'(count), 64'd5);
    stall = 1'b0;
    drive('0, '0, '0);
    for (int k = 0; k < 5; k++) tick();
    check("t5_head5_empty", 64'(count), 64'd0);
    stall = 1'b1;
    for (int g = 0; g < 3; g++) begin
      drive(2'b11, 32'h6000 + 32'(8*g), 32'h6004 + 32'(8*g));
      tick();
    end
    check("t5_count6", 64'(count), 64'd6);
    stall = 1'b0;
    drive(2'b01, 32'h6018, 32'h0);
    tick();
    check("t5_push_pop_same", 64'(count), 64'd6);
    drive(2'b11, 32'h601C, 32'h6020);
    tick();
    check("t5_count7", 64'(count), 64'd7);
    check("t5_not_ready", 64'(fetch_ready), 64'd0);
    drive(2'b11, 32'h7000, 32'h7004);
    tick();
    check("t5_count_after", 64'(count), 64'd6);
    drive('0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      check("t5_wrap_pc", 64'(out_pc[0]), 64'h600C + 64'(4*k));
      tick();
    end
    check("t5_empty", 64'(count), 64'd0);

    // Flush beats a same-cycle push
    stall = 1'b1;
    drive(2'b11, 32'h8000, 32'h8004); tick();
    drive(2'b11, 32'h8008, 32'h800C); tick();
    drive(2'b01, 32'h8010, 32'h0);    tick();
    check("t6_pre", 64'(count), 64'd5);
    stall = 1'b0;
    flush = 1'b1;
    drive(2'b11, 32'h9000, 32'h9004);
    tick();
    flush = 1'b0;
    drive('0, '0, '0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ready", 64'(fetch_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("t6_stays_empty", 64'(out_valid), 64'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 24) == 0);
      drive(FW'($urandom), $urandom, $urandom);
      if (c == 200) async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
